// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end for a single bit-serial full adder.
// One WIDTH-bit add per grant, LSB first, WIDTH cycles in RUN, one DONE cycle.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s, fa_c, pick;

  // The one shared full-adder cell.
  assign fa_s = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign fa_c = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign pick = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pick;
          last_d  = pick;
          opa_d   = pick ? a1 : a0;
          opb_d   = pick ? b1 : b0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        sr_d    = (sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the result only on the edge into DONE so sum/cout hold between ops.
          sum_d   = sr_d;
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      opa_q   <= '0;
      opb_q   <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign done_id = gnt_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Shares one bit-serial full-adder datapath between two requesters, granting them round-robin. It computes one WIDTH-bit sum per operation by clocking the operands LSB-first through a single full-adder cell, with a carry flip-flop holding the carry between bits. It sits between two client blocks and the shared adder cell, and trades throughput for area against a parallel ripple adder.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 32.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants an add; level-sensitive.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 wants an add; level-sensitive.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt  output  1  id of the requester being served; valid while busy=1.
- busy  output  1  an operation is in RUN or DONE.
- done  output  1  one-cycle pulse; the result is valid.
- done_id  output  1  id of the requester that owns the result.
- sum  output  WIDTH  (A+B) mod 2^WIDTH; held until the next done.
- cout  output  1  carry out of bit WIDTH-1; held with sum.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- In IDLE with no request, the block stays in IDLE.
- In IDLE with any request, the block grants a requester, then:
  - It latches that requester's A and B into shift registers.
  - It clears the carry flip-flop and the bit counter.
  - It sets gnt and moves to RUN.
- Arbitration:
  - If only one requester is asserting req, it wins.
  - If both are asserting, the winner is the requester not served last.
  - The last-served pointer resets so that requester 0 wins the first tie.
  - The pointer updates at grant.
- RUN:
  - Each cycle, the full adder takes opA[0], opB[0] and the carry flip-flop.
  - The sum bit shifts into the MSB of the sum shift register, shifting right.
  - opA and opB shift right, the carry flip-flop takes the adder's cout, and the counter increments.
  - After WIDTH bit-cycles, the block moves to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - sum, cout and done_id (= gnt) are presented.
  - The block then moves to IDLE.
- Operands are sampled only at grant; later changes to a*/b* have no effect.
- req is not acknowledged separately. A requester drops req in the cycle after it sees done with its id. If req is still high in IDLE, the requester is treated as a new request.
- Arithmetic: result = a + b, computed at WIDTH+1 bits; sum is the low WIDTH bits and cout is the top bit. No signed interpretation.

## Timing
- Reset values: state=IDLE, gnt=0, busy=0, done=0, done_id=0, sum=0, cout=0, carry=0, counter=0, last-served pointer=1.
- Cycle 0: in IDLE with req high. The grant and the operand latch take place on the edge ending cycle 0.
- Cycles 1..WIDTH: RUN; busy=1.
- Cycle WIDTH+1: DONE; done=1, busy=1.
- Cycle WIDTH+2: IDLE; busy=0. A new grant can latch on the edge ending this cycle.
- Latency from req to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- sum and cout update only on the edge entering DONE, and stay stable until the next DONE.
- Reset asserted in any state: all registers take their reset values on that edge. An aborted operation never produces done, and sum returns to 0.
- req edges arriving during RUN or DONE have no effect until IDLE. A requester that drops req before its done still receives its result.
- WIDTH=1: RUN lasts exactly one cycle.

## Test plan
- WIDTH=8, req0 only, a0=0x35, b0=0x4A → done in cycle 9 after req, sum=0x7F, cout=0, done_id=0.
- req1 only, a1=0xFF, b1=0x01 → sum=0x00, cout=1, done_id=1. Also cover 0xFF+0xFF → sum=0xFE, cout=1.
- req0 and req1 rise together straight after reset, each dropping req after its own done:
  - requester 0 is served first and requester 1 second;
  - the second done arrives 10 cycles after the first.
- Both reqs held high for 4 operations → done_id sequence is 0,1,0,1; busy low for exactly one cycle between operations.
- Reset asserted in the 4th RUN cycle → next cycle busy=0 and sum=0 with no done pulse. A new req0 of 0x10+0x20 gives sum=0x30.
- a0 changed from 0x01 to 0xF0 on the cycle after grant (b0=0x01) → sum=0x02, proving operands are sampled at grant.
